// File: rtl/task_stream_pkg.sv
// Shared types and helpers for the task word stream and its byte serializer.
package task_stream_pkg;

  localparam int DEFAULT_WORD_WIDTH = 16;
  localparam int DEFAULT_BYTE_WIDTH = 8;

  // Upper bounds for the generic byte-select helper below.
  localparam int MAX_WORD_WIDTH = 64;
  localparam int MAX_BYTE_WIDTH = 32;
  localparam int WORD_IDX_W     = $clog2(MAX_WORD_WIDTH);
  localparam int BYTE_IDX_W     = $clog2(MAX_BYTE_WIDTH);

  typedef struct packed {
    logic                          last;
    logic [DEFAULT_WORD_WIDTH-1:0] data;
  } fifo_entry_t;

  // Returns byte k of a word (zero-extended to MAX_WORD_WIDTH); the caller
  // truncates the result to its own byte width.
  function automatic logic [MAX_BYTE_WIDTH-1:0] byte_select(
    input logic [MAX_WORD_WIDTH-1:0] word,
    input int unsigned               k,
    input int unsigned               word_width,
    input int unsigned               byte_width,
    input bit                        msb_first
  );
    logic [MAX_BYTE_WIDTH-1:0] result;
    logic [WORD_IDX_W-1:0]     bit_idx;
    int unsigned               base;
    result = '0;
    base   = msb_first ? word_width - (k + 1) * byte_width : k * byte_width;
    for (int unsigned i = 0; i < MAX_BYTE_WIDTH; i++) begin
      if (i < byte_width) begin
        bit_idx = WORD_IDX_W'((base + i) % MAX_WORD_WIDTH);
        result[BYTE_IDX_W'(i)] = word[bit_idx];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module stream_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers alone define
  // which entries are valid, and resetting RAM would prevent memory inference.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/task_result_serializer.sv
// Buffers task output words and replays them as a byte stream with
// regenerated first/last frame flags under a valid/ready handshake.
module task_result_serializer
  import task_stream_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int BYTE_WIDTH = DEFAULT_BYTE_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  input  logic                        i_last,
  input  logic [WORD_WIDTH-1:0]       i_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_first,
  output logic                        o_last,
  output logic [BYTE_WIDTH-1:0]       o_data,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_overflow
);

  localparam int BYTES_PER_WORD = WORD_WIDTH / BYTE_WIDTH;
  localparam int KW             = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BYTES_PER_WORD - 1);

  typedef struct packed {
    logic                  last;
    logic [WORD_WIDTH-1:0] data;
  } entry_t;

  entry_t                push_entry;
  entry_t                head;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  handshake;
  logic                  k_at_last;
  logic [KW-1:0]         k;
  logic [KW-1:0]         k_next;
  logic                  first_pending;
  logic                  first_pending_next;
  logic                  overflow;
  logic [BYTE_WIDTH-1:0] sel_byte;

  assign push_entry = '{last: i_last, data: i_data};

  stream_sync_fifo #(
    .WIDTH (WORD_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst),
    .push  (i_valid),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (o_level)
  );

  assign o_valid   = !fifo_empty;
  assign handshake = o_valid && i_ready;
  assign k_at_last = (k == K_LAST);
  assign pop       = handshake && k_at_last;
  assign sel_byte  = BYTE_WIDTH'(byte_select(MAX_WORD_WIDTH'(head.data), 32'(k),
                                             WORD_WIDTH, BYTE_WIDTH, MSB_FIRST));

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    k_next             = k;
    first_pending_next = first_pending;
    if (handshake) begin
      k_next = k_at_last ? '0 : k + KW'(1);
      if (o_first) first_pending_next = 1'b0;
      // Ordered after the clear so a single-byte frame re-arms the flag.
      if (o_last)  first_pending_next = 1'b1;
    end
  end

  always_comb begin
    o_first = 1'b0;
    o_last  = 1'b0;
    o_data  = '0;
    if (o_valid) begin
      o_first = first_pending && (k == '0);
      o_last  = head.last && k_at_last;
      o_data  = sel_byte;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      k             <= '0;
      first_pending <= 1'b1;
      overflow      <= 1'b0;
    end else begin
      k             <= k_next;
      first_pending <= first_pending_next;
      if (i_valid && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign o_overflow = overflow;

endmodule

// File: tb/tb_task_result_serializer.sv
// Directed bench: MSB-first and LSB-first serializers driven by one stimulus.
module tb_task_result_serializer;

  logic        i_clk   = 1'b0;
  logic        i_rst   = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_last  = 1'b0;
  logic        i_ready = 1'b0;
  logic [15:0] i_data  = '0;

  logic        o_valid, o_first, o_last, o_overflow;
  logic [7:0]  o_data;
  logic [4:0]  o_level;
  logic        l_valid, l_first, l_last, l_overflow;
  logic [7:0]  l_data;
  logic [4:0]  l_level;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  task_result_serializer #(.WORD_WIDTH(16), .BYTE_WIDTH(8), .FIFO_DEPTH(16), .MSB_FIRST(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_last(i_last), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_first(o_first), .o_last(o_last),
    .o_data(o_data), .o_level(o_level), .o_overflow(o_overflow)
  );

  task_result_serializer #(.WORD_WIDTH(16), .BYTE_WIDTH(8), .FIFO_DEPTH(16), .MSB_FIRST(1'b0)) dut_lsb (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_last(i_last), .i_data(i_data),
    .o_valid(l_valid), .i_ready(i_ready), .o_first(l_first), .o_last(l_last),
    .o_data(l_data), .o_level(l_level), .o_overflow(l_overflow)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] w, input logic l);
    i_valid = 1'b1;
    i_data  = w;
    i_last  = l;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = '0;
  endtask

  logic [15:0] words3 [3];
  logic [7:0]  bytes6 [6];
  logic [15:0] exp_w;

  initial begin
    words3 = '{16'h0102, 16'h0304, 16'h0506};
    bytes6 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

    // Reset state
    #1;
    check("rst_valid",    32'(o_valid),    32'h0);
    check("rst_first",    32'(o_first),    32'h0);
    check("rst_last",     32'(o_last),     32'h0);
    check("rst_data",     32'(o_data),     32'h0);
    check("rst_level",    32'(o_level),    32'h0);
    check("rst_overflow", 32'(o_overflow), 32'h0);
    tick();
    tick();
    i_rst = 1'b1;
    tick();

    // Single word, ready high
    i_ready = 1'b1;
    push(16'hA55A, 1'b1);
    tick();
    idle();
    check("t1_valid", 32'(o_valid), 32'h1);
    check("t1_b0",    32'(o_data),  32'hA5);
    check("t1_f0",    32'(o_first), 32'h1);
    check("t1_l0",    32'(o_last),  32'h0);
    check("t1_lvl0",  32'(o_level), 32'h1);
    tick();
    check("t1_b1",    32'(o_data),  32'h5A);
    check("t1_f1",    32'(o_first), 32'h0);
    check("t1_l1",    32'(o_last),  32'h1);
    check("t1_lvl1",  32'(o_level), 32'h1);
    tick();
    check("t1_empty", 32'(o_valid), 32'h0);
    check("t1_lvl2",  32'(o_level), 32'h0);
    check("t1_data0", 32'(o_data),  32'h0);

    // Backpressure for five cycles
    i_ready = 1'b0;
    push(16'hA55A, 1'b1);
    tick();
    idle();
    for (int c = 0; c < 5; c++) begin
      check("t2_hold_valid", 32'(o_valid), 32'h1);
      check("t2_hold_data",  32'(o_data),  32'hA5);
      check("t2_hold_first", 32'(o_first), 32'h1);
      tick();
    end
    i_ready = 1'b1;
    check("t2_b0", 32'(o_data), 32'hA5);
    tick();
    check("t2_b1", 32'(o_data), 32'h5A);
    check("t2_l1", 32'(o_last), 32'h1);
    tick();
    check("t2_empty", 32'(o_valid), 32'h0);

    // Three-word frame streamed back to back
    for (int i = 0; i < 6; i++) begin
      if (i < 3) push(words3[i], i == 2);
      else idle();
      tick();
      check("t3_valid", 32'(o_valid), 32'h1);
      check("t3_data",  32'(o_data),  32'(bytes6[i]));
      check("t3_first", 32'(o_first), 32'(i == 0));
      check("t3_last",  32'(o_last),  32'(i == 5));
    end
    idle();
    tick();
    check("t3_empty", 32'(o_valid), 32'h0);
    push(16'h0708, 1'b1);
    tick();
    idle();
    check("t3_next_first", 32'(o_first), 32'h1);
    check("t3_next_data",  32'(o_data),  32'h07);
    tick();
    check("t3_next_b1",    32'(o_data),  32'h08);
    tick();

    // Fill to capacity, then two dropped words
    i_ready = 1'b0;
    for (int w = 0; w < 16; w++) begin
      push(16'(w), 1'b0);
      tick();
    end
    check("t4_full_level", 32'(o_level),    32'd16);
    check("t4_no_ovf_yet", 32'(o_overflow), 32'h0);
    for (int w = 16; w < 18; w++) begin
      push(16'(w), 1'b0);
      tick();
    end
    idle();
    check("t4_level",    32'(o_level),    32'd16);
    check("t4_overflow", 32'(o_overflow), 32'h1);
    check("t4_head_hi",  32'(o_data),     32'h00);
    check("t4_head_f",   32'(o_first),    32'h1);

    // Pop on the final byte while pushing into the full FIFO
    i_ready = 1'b1;
    tick();
    check("t5_head_lo", 32'(o_data), 32'h00);
    push(16'h0012, 1'b1);
    tick();
    idle();
    check("t5_level",    32'(o_level),    32'd16);
    check("t5_overflow", 32'(o_overflow), 32'h1);
    for (int n = 1; n <= 16; n++) begin
      exp_w = (n == 16) ? 16'h0012 : 16'(n);
      check("t4_drain_hi", 32'(o_data), 32'(exp_w[15:8]));
      tick();
      check("t4_drain_lo",   32'(o_data), 32'(exp_w[7:0]));
      check("t4_drain_last", 32'(o_last), 32'(n == 16));
      tick();
    end
    check("t4_drained_valid", 32'(o_valid), 32'h0);
    check("t4_drained_level", 32'(o_level), 32'h0);

    // Asynchronous reset after the first byte of a word
    push(16'h1234, 1'b1);
    tick();
    idle();
    check("t6_b0", 32'(o_data), 32'h12);
    tick();
    check("t6_b1", 32'(o_data), 32'h34);
    i_rst = 1'b0;
    #1;
    check("t6_rst_valid",    32'(o_valid),    32'h0);
    check("t6_rst_data",     32'(o_data),     32'h0);
    check("t6_rst_first",    32'(o_first),    32'h0);
    check("t6_rst_last",     32'(o_last),     32'h0);
    check("t6_rst_level",    32'(o_level),    32'h0);
    check("t6_rst_overflow", 32'(o_overflow), 32'h0);
    check("t6_rst_lsb_vld",  32'(l_valid),    32'h0);
    #2;
    i_rst = 1'b1;
    tick();
    push(16'h5678, 1'b1);
    tick();
    idle();
    check("t6_msb_b0",    32'(o_data),  32'h56);
    check("t6_msb_f0",    32'(o_first), 32'h1);
    check("t6_lsb_b0",    32'(l_data),  32'h78);
    check("t6_lsb_f0",    32'(l_first), 32'h1);
    tick();
    check("t6_msb_b1",    32'(o_data),  32'h78);
    check("t6_msb_l1",    32'(o_last),  32'h1);
    check("t6_lsb_b1",    32'(l_data),  32'h56);
    check("t6_lsb_l1",    32'(l_last),  32'h1);
    tick();
    check("t6_msb_empty", 32'(o_valid), 32'h0);
    check("t6_lsb_empty", 32'(l_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/task_result_serializer.md
Name: task_result_serializer

Overview:
- Consumes the word stream produced by a task block (o_valid/o_last/o_data, no backpressure) and converts it back into a byte stream for the UART transmit path.
- Words are buffered in an internal FIFO and then emitted one byte at a time under a valid/ready handshake.
- Frame boundaries are regenerated as first/last byte flags.
- Sits between the task output and the UART TX framer: it is the return-path counterpart of the byte-to-task input stream.

Parameters:
- WORD_WIDTH, 16: input word width; must be an integer multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: output byte width.
- FIFO_DEPTH, 16: words buffered; power of two, minimum 2.
- MSB_FIRST, 1: 1 = most-significant byte sent first; 0 = least-significant byte first.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  asynchronous, active-low reset (asserted when 0).
- i_valid  in  1  input word valid; sampled each cycle, no backpressure to the source.
- i_last  in  1  word is the final word of its frame.
- i_data  in  WORD_WIDTH  input word.
- o_valid  out  1  output byte valid.
- i_ready  in  1  downstream accepts the byte when o_valid && i_ready.
- o_first  out  1  byte is the first byte of a frame.
- o_last  out  1  byte is the final byte of a frame.
- o_data  out  BYTE_WIDTH  output byte.
- o_level  out  $clog2(FIFO_DEPTH)+1  words currently held in the FIFO.
- o_overflow  out  1  sticky: at least one input word was dropped.

Behaviour:
- Derived constant: BYTES_PER_WORD = WORD_WIDTH/BYTE_WIDTH.
- Reset (i_rst=0, asynchronous):
  - FIFO pointers and o_level return to 0.
  - Byte index returns to 0.
  - first_pending = 1.
  - o_overflow = 0.
  - o_valid = 0, o_first = 0, o_last = 0, o_data = 0.
- Reset mid-frame discards all buffered words and any partially sent word. The first byte after reset carries o_first = 1.
- FIFO entry: {last, data}, width WORD_WIDTH+1. A push happens when i_valid = 1 and the FIFO is not full.
- Push while full:
  - The word is dropped and o_overflow is set; it stays set until reset.
  - If a word pop occurs in the same cycle, the FIFO is not considered full and the push succeeds.
- Latency: a word pushed at edge N makes o_valid = 1 from the cycle after edge N, provided the FIFO was empty.
- Output, combinational from the FIFO head and the byte index:
  - o_valid = FIFO not empty.
  - o_data = byte selected by index k. MSB_FIRST = 1 sends bits [WORD_WIDTH-1-k*BYTE_WIDTH -: BYTE_WIDTH]; MSB_FIRST = 0 sends [k*BYTE_WIDTH +: BYTE_WIDTH].
  - o_first = first_pending && k == 0.
  - o_last = head.last && k == BYTES_PER_WORD-1.
  - When o_valid = 0, o_first, o_last and o_data are driven 0.
- Byte phase state machine, index k in 0..BYTES_PER_WORD-1:
  - On a handshake with k < BYTES_PER_WORD-1: k increments.
  - On a handshake with k == BYTES_PER_WORD-1: k wraps to 0 and the head word is popped.
  - No handshake: hold k.
- first_pending:
  - Cleared on the handshake of a byte that has o_first = 1.
  - Set on the handshake of a byte that has o_last = 1.
  - Set wins if both occur together, which is only possible when BYTES_PER_WORD = 1 and the frame is one word.
- Stability: while o_valid && !i_ready, o_data, o_first and o_last stay stable. New pushes never alter the head entry.
- o_level: +1 on push, -1 on pop, unchanged when both happen in the same cycle. Range 0..FIFO_DEPTH.
- Pointer width: $clog2(FIFO_DEPTH)+1 with a wrap bit. Full is declared when the pointers are equal except for the MSB.
- Input words with i_valid = 0 are ignored. Frames without i_last continue to concatenate; no timeout.

Decomposition:
- Package task_stream_pkg holds:
  - WORD_WIDTH and BYTE_WIDTH defaults.
  - The typedef for a FIFO entry, struct {logic last; logic [WORD_WIDTH-1:0] data;}.
  - A byte-select function parameterised by MSB_FIRST.
- Sub-module stream_sync_fifo:
  - Single clock, asynchronous active-low reset.
  - Ports: push, pop, din, dout (first-word fall-through), empty, full, level.
  - Reusable on the input path.
- The top level holds the byte-phase logic, first_pending and overflow.

Test Plan:
- One word 0xA55A with i_last = 1, i_ready = 1 -> 0xA5 (first = 1, last = 0), then 0x5A (first = 0, last = 1), on consecutive cycles starting the cycle after the push. o_level goes 1 -> 0.
- Same word with i_ready held 0 for 5 cycles, then 1 -> o_valid = 1 and o_data = 0xA5 stable for all 5 cycles; then 0xA5, 0x5A with no loss or duplication.
- Back-to-back frame 0x0102, 0x0304, 0x0506 (last on the third word), ready = 1 -> bytes 01..06. o_first only on 01, o_last only on 06. The next frame's first byte has o_first = 1.
- i_ready = 0 while pushing FIFO_DEPTH+2 words 0x0000..0x0011 -> o_level = 16, o_overflow = 1. Draining yields exactly words 0x0000..0x000F.
- Full FIFO with a pop on the final byte and a push in the same cycle -> push accepted, o_level stays 16, o_overflow unchanged.
- Reset asserted after the first byte of 0x1234 is accepted -> all outputs 0 immediately. After release, push 0x5678 -> 0x56 with o_first = 1. With MSB_FIRST = 0, the same push yields 0x78 then 0x56.
